dither_requant_4: RTL and testbench

- Applies high-pass triangular dither to four parallel high-resolution samples per clock (4x-rate lanes), rounds, and saturates to DAC width.
- Sits between the 4x-rate DSP datapath and the DAC output serializer.
- Consumes the 9-bit offset-binary dither words from the existing 4-lane dither generator.
- Provides clip monitoring for the control processor.

---
 rtl/dither_requant_4_pkg.sv | 35 +++
 rtl/dither_requant_4_lane.sv | 57 +++++
 rtl/dither_requant_4.sv | 87 ++++++++
 tb/tb_dither_requant_4.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dither_requant_4_pkg.sv
// Shared constants and saturating requantization helper for the 4-lane dither requantizer.
package dither_requant_4_pkg;

  localparam int unsigned DITHER_W = 9;
  localparam logic [DITHER_W-1:0] DITHER_ZERO = 9'h100;

  typedef struct packed {
    logic               clip;
    logic signed [63:0] q;
  } sat_t;

  // Floor shift by sh, then clamp to the signed ow-bit range; clip flags a clamp.
  function automatic sat_t sat_shift(input logic signed [63:0] s,
                                     input int unsigned sh,
                                     input int unsigned ow);
    sat_t               res;
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    q        = s >>> sh;
    hi       = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo       = -(64'sd1 <<< (ow - 1));
    res.clip = 1'b1;
    if (q > hi) begin
      res.q = hi;
    end else if (q < lo) begin
      res.q = lo;
    end else begin
      res.q    = q;
      res.clip = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dither_requant_4_lane.sv
// One lane: register sample and signed dither, add scaled dither plus rounding half, floor-shift and saturate.
module dither_requant_lane
  import dither_requant_4_pkg::*;
#(
  parameter int unsigned IW = 24,
  parameter int unsigned OW = 16
) (
  input  logic                c,
  input  logic                r,
  input  logic [IW-1:0]       x,
  input  logic [DITHER_W-1:0] d,
  input  logic                dither_en,
  output logic [OW-1:0]       y,
  output logic                clip
);

  localparam int unsigned SH = IW - OW;

  if (IW < OW + 8) begin : g_width_check
    $error("dither_requant_lane: IW-OW must be at least 8");
  end

  logic signed [IW-1:0]     x1;
  logic signed [DITHER_W:0] ds1;
  logic signed [IW+1:0]     s2;
  logic signed [IW+1:0]     xe;
  logic signed [IW+1:0]     de;
  logic signed [IW+1:0]     half;
  sat_t                     sat;
  logic                     unused_q;

  always_ff @(posedge c) begin
    if (r) begin
      x1  <= '0;
      ds1 <= '0;
      s2  <= '0;
      y   <= '0;
    end else begin
      x1  <= x;
      ds1 <= dither_en ? $signed({1'b0, d}) - $signed({1'b0, DITHER_ZERO}) : '0;
      s2  <= xe + de + half;
      y   <= sat.q[OW-1:0];
    end
  end

  // Dither is aligned so its LSB sits 8 bits below the output LSB.
  always_comb begin
    xe   = {{2{x1[IW-1]}}, x1};
    de   = {{(IW + 2 - DITHER_W - 1){ds1[DITHER_W]}}, ds1} <<< (SH - 8);
    half = (IW + 2)'(1) << (SH - 1);
    sat  = sat_shift({{(64 - IW - 2){s2[IW+1]}}, s2}, SH, OW);
    clip = sat.clip;
  end

  assign unused_q = ^sat.q[63:OW];

endmodule

// File: rtl/dither_requant_4.sv
// Four-lane dithered requantizer: lane datapaths plus valid pipeline, sticky clip flags and clip counter.
module dither_requant_4
  import dither_requant_4_pkg::*;
#(
  parameter int unsigned IW = 24,
  parameter int unsigned OW = 16
) (
  input  logic                c,
  input  logic                r,
  input  logic                v_in,
  input  logic [IW-1:0]       x0,
  input  logic [IW-1:0]       x1,
  input  logic [IW-1:0]       x2,
  input  logic [IW-1:0]       x3,
  input  logic [DITHER_W-1:0] d0,
  input  logic [DITHER_W-1:0] d1,
  input  logic [DITHER_W-1:0] d2,
  input  logic [DITHER_W-1:0] d3,
  input  logic                dither_en,
  input  logic                clip_clr,
  output logic                v_out,
  output logic [OW-1:0]       y0,
  output logic [OW-1:0]       y1,
  output logic [OW-1:0]       y2,
  output logic [OW-1:0]       y3,
  output logic [3:0]          clip_sticky,
  output logic [15:0]         clip_count
);

  logic [IW-1:0]       xa [4];
  logic [DITHER_W-1:0] da [4];
  logic [OW-1:0]       ya [4];
  logic [3:0]          clip;
  logic [2:0]          vp;

  assign xa[0] = x0;
  assign xa[1] = x1;
  assign xa[2] = x2;
  assign xa[3] = x3;
  assign da[0] = d0;
  assign da[1] = d1;
  assign da[2] = d2;
  assign da[3] = d3;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dither_requant_lane #(
      .IW(IW),
      .OW(OW)
    ) u_lane (
      .c        (c),
      .r        (r),
      .x        (xa[i]),
      .d        (da[i]),
      .dither_en(dither_en),
      .y        (ya[i]),
      .clip     (clip[i])
    );
  end

  assign y0    = ya[0];
  assign y1    = ya[1];
  assign y2    = ya[2];
  assign y3    = ya[3];
  assign v_out = vp[2];

  // Lane clip is the clamp of the value being loaded into y, so flags update
  // on the same edge that presents the sample with v_out.
  always_ff @(posedge c) begin
    if (r) begin
      vp          <= '0;
      clip_sticky <= '0;
      clip_count  <= '0;
    end else begin
      vp <= {vp[1:0], v_in};
      if (clip_clr) begin
        clip_sticky <= '0;
        clip_count  <= '0;
      end else if (vp[1]) begin
        clip_sticky <= clip_sticky | clip;
        if (|clip && clip_count != '1) begin
          clip_count <= clip_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dither_requant_4.sv
// Self-checking bench for dither_requant_4: arithmetic reference model, directed literals, random regression.
module tb_dither_requant_4;

  localparam int SH = 8;

  typedef struct packed {
    logic             v;
    logic [3:0]       clip;
    logic [3:0][15:0] y;
  } rec_t;

  logic        c = 1'b0;
  logic        r, v_in, dither_en, clip_clr;
  logic [23:0] xi [4];
  logic [8:0]  di [4];
  logic        v_out;
  logic [15:0] y0, y1, y2, y3;
  logic [3:0]  clip_sticky;
  logic [15:0] clip_count;

  int          nchk = 0;
  int          nerr = 0;
  rec_t        pq[$];
  rec_t        eo;
  logic [3:0]  esticky;
  logic [15:0] ecount;
  longint      ysum;
  longint      ycnt;
  real         ymean;

  dither_requant_4 #(.IW(24), .OW(16)) dut (
    .c(c), .r(r), .v_in(v_in),
    .x0(xi[0]), .x1(xi[1]), .x2(xi[2]), .x3(xi[3]),
    .d0(di[0]), .d1(di[1]), .d2(di[2]), .d3(di[3]),
    .dither_en(dither_en), .clip_clr(clip_clr),
    .v_out(v_out), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .clip_sticky(clip_sticky), .clip_count(clip_count)
  );

  always #5 c = ~c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic: value = x + dither*2^(SH-8) + half LSB, floor-divide by 2^SH, clamp.
  function automatic rec_t model_in();
    rec_t   t;
    longint xv, ds, val, q;
    t   = '0;
    t.v = v_in;
    for (int i = 0; i < 4; i++) begin
      xv  = longint'($signed(xi[i]));
      ds  = dither_en ? longint'(di[i]) - longint'(256) : longint'(0);
      val = xv + ds * (longint'(1) << (SH - 8)) + (longint'(1) << (SH - 1));
      q   = val >>> SH;
      if (q > longint'(32767)) begin
        q = 32767;
        t.clip[i] = 1'b1;
      end else if (q < longint'(-32768)) begin
        q = -32768;
        t.clip[i] = 1'b1;
      end
      t.y[i] = q[15:0];
    end
    return t;
  endfunction

  task automatic step();
    rec_t nw;
    nw = model_in();
    @(posedge c);
    if (r) begin
      pq.delete();
      pq.push_back('0);
      pq.push_back('0);
      eo      = '0;
      esticky = '0;
      ecount  = '0;
    end else begin
      pq.push_back(nw);
      eo = pq.pop_front();
      if (clip_clr) begin
        esticky = '0;
        ecount  = '0;
      end else if (eo.v) begin
        esticky = esticky | eo.clip;
        if (eo.clip != 4'b0 && ecount != 16'hFFFF) ecount = ecount + 16'd1;
      end
    end
    #1;
    chk("v_out", 32'(v_out), 32'(eo.v));
    chk("y0", 32'(y0), 32'(eo.y[0]));
    chk("y1", 32'(y1), 32'(eo.y[1]));
    chk("y2", 32'(y2), 32'(eo.y[2]));
    chk("y3", 32'(y3), 32'(eo.y[3]));
    chk("clip_sticky", 32'(clip_sticky), 32'(esticky));
    chk("clip_count", 32'(clip_count), 32'(ecount));
  endtask

  task automatic set_lane(input int i, input logic [23:0] xv, input logic [8:0] dv);
    xi[i] = xv;
    di[i] = dv;
  endtask

  initial begin
    r = 1'b1; v_in = 1'b1; dither_en = 1'b1; clip_clr = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 24'h123456, 9'h1A0);
    esticky = '0; ecount = '0; eo = '0;

    // Reset holds everything at zero even with valid nonzero input.
    repeat (3) step();
    chk("rst_y0", 32'(y0), 32'h0);
    chk("rst_y3", 32'(y3), 32'h0);
    chk("rst_v_out", 32'(v_out), 32'h0);
    chk("rst_count", 32'(clip_count), 32'h0);
    chk("rst_sticky", 32'(clip_sticky), 32'h0);

    r = 1'b0; v_in = 1'b1;
    step(); chk("rel_lat1", 32'(v_out), 32'h0);
    v_in = 1'b0;
    step(); chk("rel_lat2", 32'(v_out), 32'h0);
    step(); chk("rel_lat3", 32'(v_out), 32'h1);
    step(); chk("rel_lat4", 32'(v_out), 32'h0);

    // Round-half-up without dither.
    dither_en = 1'b0;
    set_lane(0, 24'h000180, 9'h100);
    set_lane(1, 24'h00017F, 9'h100);
    set_lane(2, 24'hFFFE80, 9'h100);
    set_lane(3, 24'h000000, 9'h100);
    v_in = 1'b1; step();
    v_in = 1'b0; step(); chk("rnd_lat2", 32'(v_out), 32'h0);
    step();
    chk("rnd_v", 32'(v_out), 32'h1);
    chk("rnd_y0", 32'(y0), 32'h0002);
    chk("rnd_y1", 32'(y1), 32'h0001);
    chk("rnd_y2", 32'(y2), 32'hFFFF);
    chk("rnd_y3", 32'(y3), 32'h0000);

    // Dither extremes.
    dither_en = 1'b1;
    set_lane(0, 24'h000100, 9'h1FF);
    set_lane(1, 24'h000100, 9'h001);
    set_lane(2, 24'h000100, 9'h100);
    set_lane(3, 24'h000100, 9'h1FF);
    v_in = 1'b1; step();
    v_in = 1'b0; step(); step();
    chk("dth_v", 32'(v_out), 32'h1);
    chk("dth_max", 32'(y0), 32'h0002);
    chk("dth_min", 32'(y1), 32'h0000);
    chk("dth_zero", 32'(y2), 32'h0001);
    chk("dth_max3", 32'(y3), 32'h0002);

    clip_clr = 1'b1; step(); clip_clr = 1'b0;

    // Saturation both ways.
    set_lane(0, 24'h7FFFC0, 9'h1FF);
    set_lane(1, 24'h800000, 9'h001);
    set_lane(2, 24'h000000, 9'h100);
    set_lane(3, 24'h000000, 9'h100);
    v_in = 1'b1; step();
    v_in = 1'b0; step(); step();
    chk("sat_pos", 32'(y0), 32'h7FFF);
    chk("sat_neg", 32'(y1), 32'h8000);
    chk("sat_sticky", 32'(clip_sticky), 32'h3);
    chk("sat_count", 32'(clip_count), 32'h1);
    repeat (4) step();
    chk("sat_inval_count", 32'(clip_count), 32'h1);
    chk("sat_inval_sticky", 32'(clip_sticky), 32'h3);

    // Clear coincident with a recorded clip: clear wins.
    v_in = 1'b1; step();
    v_in = 1'b0; step();
    clip_clr = 1'b1; step();
    chk("clr_v", 32'(v_out), 32'h1);
    chk("clr_y0", 32'(y0), 32'h7FFF);
    chk("clr_count", 32'(clip_count), 32'h0);
    chk("clr_sticky", 32'(clip_sticky), 32'h0);
    clip_clr = 1'b0; step();
    chk("clr_hold_count", 32'(clip_count), 32'h0);
    chk("clr_hold_sticky", 32'(clip_sticky), 32'h0);

    // Counter saturation on lane 0 while lanes 1..3 measure dithered mean at 1.25 LSB.
    set_lane(0, 24'h7FFFC0, 9'h1FF);
    for (int i = 1; i < 4; i++) set_lane(i, 24'h000140, 9'h100);
    ysum = 0; ycnt = 0;
    v_in = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      for (int i = 1; i < 4; i++) di[i] = 9'(1 + (k * 3 + i) % 511);
      step();
      if (v_out) begin
        ysum += longint'($signed(y1)) + longint'($signed(y2)) + longint'($signed(y3));
        ycnt += 3;
      end
    end
    v_in = 1'b0;
    chk("cnt_sat", 32'(clip_count), 32'hFFFF);
    chk("cnt_sticky", 32'(clip_sticky), 32'h1);
    ymean = (ycnt > 0) ? real'(ysum) / real'(ycnt) : 0.0;
    nchk++;
    if (!(ymean > 1.24 && ymean < 1.26)) begin
      nerr++;
      $display("FAIL dither_mean: actual=%f required=1.25+-0.01 (n=%0d)", ymean, ycnt);
    end

    clip_clr = 1'b1; step(); clip_clr = 1'b0;

    // Random regression including mid-stream resets and clears.
    for (int k = 0; k < 3000; k++) begin
      r         = ($urandom_range(0, 99) == 0);
      v_in      = 1'($urandom_range(0, 1));
      dither_en = ($urandom_range(0, 3) != 0);
      clip_clr  = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       xi[i] = 24'h7FFF00 + 24'($urandom_range(0, 255));
          1:       xi[i] = 24'h800000 + 24'($urandom_range(0, 255));
          default: xi[i] = 24'($urandom);
        endcase
        di[i] = 9'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
